// File: rtl/leg_branch_pkg.sv
// Shared types and opcode field positions for the LEG branch sequencer.
package leg_branch_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    LT = 4'd2,
    LE = 4'd3,
    GT = 4'd4,
    GE = 4'd5
  } cond_e;

  typedef enum logic [1:0] {
    RUN,
    EVAL,
    FLUSH
  } state_e;

  localparam int OP_BRANCH_BIT = 5;
  localparam int OP_SIGNED_BIT = 4;

endpackage

// File: rtl/leg_cond_eval.sv
// Branch condition evaluator: one equality and one less-than compare, all other
// relations derived from those two.
module leg_cond_eval
  import leg_branch_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       signed_sel,
  input  logic [3:0] code,
  output logic       cond,
  output logic       illegal_code
);

  logic eq;
  logic lt;

  assign eq = (a == b);
  assign lt = signed_sel ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    cond         = 1'b0;
    illegal_code = 1'b0;
    case (code)
      EQ:      cond = eq;
      NE:      cond = ~eq;
      LT:      cond = lt;
      LE:      cond = lt | eq;
      GT:      cond = ~(lt | eq);
      GE:      cond = ~lt;
      default: illegal_code = 1'b1;
    endcase
  end

endmodule

// File: rtl/leg_branch_sequencer.sv
// Program-counter sequencer: sequential instructions advance pc in one cycle,
// conditional branches spend one EVAL cycle and, when taken, one FLUSH cycle.
module leg_branch_sequencer
  import leg_branch_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter int                  PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [7:0]          opcode,
  input  logic [7:0]          arg1,
  input  logic [7:0]          arg2,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                flush,
  output logic                taken,
  output logic                illegal,
  output logic [7:0]          taken_count
);

  state_e              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next, pc_step;
  logic                flush_reg, flush_next;
  logic                illegal_reg, illegal_next;
  logic [7:0]          count_reg, count_next;
  logic                latch_en;

  logic [7:0]          a_reg, b_reg;
  logic                signed_reg;
  logic [3:0]          code_reg;
  logic [PC_WIDTH-1:0] target_reg;

  logic                cond;
  logic                illegal_code;
  logic                accept;
  logic                unused_opcode_bits;

  assign unused_opcode_bits = ^opcode[7:6];

  leg_cond_eval u_cond_eval (
    .a            (a_reg),
    .b            (b_reg),
    .signed_sel   (signed_reg),
    .code         (code_reg),
    .cond         (cond),
    .illegal_code (illegal_code)
  );

  assign instr_ready = (state_reg == RUN);
  assign accept      = instr_valid & instr_ready;
  assign pc_step     = pc_reg + PC_WIDTH'(PC_STEP);

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    flush_next   = 1'b0;
    illegal_next = illegal_reg;
    count_next   = count_reg;
    latch_en     = 1'b0;
    case (state_reg)
      RUN: begin
        if (accept) begin
          if (opcode[OP_BRANCH_BIT]) begin
            latch_en   = 1'b1;
            state_next = EVAL;
          end else begin
            pc_next = pc_step;
          end
        end
      end
      EVAL: begin
        // Reserved codes never report cond, so they fall through as not-taken.
        if (cond) begin
          pc_next    = target_reg;
          flush_next = 1'b1;
          state_next = FLUSH;
          if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
        end else begin
          pc_next    = pc_step;
          state_next = RUN;
        end
        if (illegal_code) illegal_next = 1'b1;
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RUN;
      pc_reg      <= RESET_PC;
      flush_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= 8'd0;
      a_reg       <= 8'd0;
      b_reg       <= 8'd0;
      signed_reg  <= 1'b0;
      code_reg    <= 4'd0;
      target_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      flush_reg   <= flush_next;
      illegal_reg <= illegal_next;
      count_reg   <= count_next;
      if (latch_en) begin
        a_reg      <= arg1;
        b_reg      <= arg2;
        signed_reg <= opcode[OP_SIGNED_BIT];
        code_reg   <= opcode[3:0];
        target_reg <= target;
      end
    end
  end

  // flush and taken are the same event seen by two consumers.
  assign pc          = pc_reg;
  assign flush       = flush_reg;
  assign taken       = flush_reg;
  assign illegal     = illegal_reg;
  assign taken_count = count_reg;

endmodule

// File: tb/tb_leg_branch_sequencer.sv
// Bench for leg_branch_sequencer: directed vector table, multi-cycle corner
// sequences and randomized instructions against a transaction-level model.
module tb_leg_branch_sequencer;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] arg1;
  logic [7:0] arg2;
  logic [7:0] target;
  logic [7:0] pc;
  logic       flush;
  logic       taken;
  logic       illegal;
  logic [7:0] taken_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  logic [7:0] m_pc;
  logic [7:0] m_cnt;
  logic       m_ill;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] tgt;
    bit         tk;
  } vec_t;

  vec_t vecs[11];

  leg_branch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .arg1        (arg1),
    .arg2        (arg2),
    .target      (target),
    .pc          (pc),
    .flush       (flush),
    .taken       (taken),
    .illegal     (illegal),
    .taken_count (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Relations evaluated directly on integers, with the operand
  // interpretation chosen by the signed bit.
  function automatic bit ref_taken(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    x = op[4] ? int'($signed(a)) : int'(a);
    y = op[4] ? int'($signed(b)) : int'(b);
    case (op[3:0])
      4'd0:    return x == y;
      4'd1:    return x != y;
      4'd2:    return x < y;
      4'd3:    return x <= y;
      4'd4:    return x > y;
      4'd5:    return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  // Entered and left on a falling edge with the sequencer in RUN.
  task automatic do_instr(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] tgt, input bit exp_tk);
    chk("run_ready", int'(instr_ready), 1);
    instr_valid = 1'b1;
    opcode      = op;
    arg1        = a1;
    arg2        = a2;
    target      = tgt;
    @(negedge clk);
    instr_valid = 1'b0;
    if (!op[5]) begin
      m_pc = m_pc + 8'd4;
      chk("seq_pc", int'(pc), int'(m_pc));
      chk("seq_flush", int'(flush), 0);
    end else begin
      chk("eval_ready", int'(instr_ready), 0);
      chk("eval_pc_held", int'(pc), int'(m_pc));
      @(negedge clk);
      if (op[3:0] > 4'd5) m_ill = 1'b1;
      if (exp_tk) begin
        m_pc  = tgt;
        m_cnt = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
      end else begin
        m_pc = m_pc + 8'd4;
      end
      chk("br_pc", int'(pc), int'(m_pc));
      chk("br_taken", int'(taken), int'(exp_tk));
      chk("br_flush", int'(flush), int'(exp_tk));
      chk("br_illegal", int'(illegal), int'(m_ill));
      chk("br_count", int'(taken_count), int'(m_cnt));
      if (exp_tk) begin
        chk("flush_ready", int'(instr_ready), 0);
        @(negedge clk);
        chk("post_flush", int'(flush), 0);
        chk("post_taken", int'(taken), 0);
      end
    end
    $display("txn %0d op=%02h a=%02h b=%02h tgt=%02h pc=%02h cnt=%0d ill=%0d",
             n_txn, op, a1, a2, tgt, pc, taken_count, illegal);
    n_txn++;
  endtask

  initial begin
    vecs[0]  = '{8'h20, 8'h05, 8'h05, 8'h40, 1'b1}; // EQ
    vecs[1]  = '{8'h22, 8'h80, 8'h01, 8'h90, 1'b0}; // LT unsigned
    vecs[2]  = '{8'h32, 8'h80, 8'h01, 8'h10, 1'b1}; // LT signed
    vecs[3]  = '{8'h21, 8'h03, 8'h03, 8'h20, 1'b0}; // NE
    vecs[4]  = '{8'h23, 8'h07, 8'h07, 8'h33, 1'b1}; // LE, misaligned target
    vecs[5]  = '{8'h24, 8'hFF, 8'h7F, 8'hFC, 1'b1}; // GT unsigned
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0}; // sequential, 252 -> 0
    vecs[7]  = '{8'h27, 8'h01, 8'h01, 8'h50, 1'b0}; // reserved code 7
    vecs[8]  = '{8'h35, 8'hFF, 8'h01, 8'h60, 1'b0}; // GE signed
    vecs[9]  = '{8'h34, 8'h01, 8'hFF, 8'h80, 1'b1}; // GT signed
    vecs[10] = '{8'h2F, 8'h02, 8'h09, 8'h70, 1'b0}; // reserved code 15

    rst         = 1'b1;
    instr_valid = 1'b1;
    opcode      = 8'h00;
    arg1        = 8'h00;
    arg2        = 8'h00;
    target      = 8'h00;
    m_pc        = 8'h00;
    m_cnt       = 8'h00;
    m_ill       = 1'b0;

    // Reset with a valid instruction pending: nothing may be accepted.
    repeat (2) @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_taken", int'(taken), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_count", int'(taken_count), 0);
    chk("rst_ready", int'(instr_ready), 1);

    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("idle_pc", int'(pc), 0);

    // Back-to-back sequential instructions, one per cycle.
    instr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("b2b_pc", int'(pc), 4 * i);
      chk("b2b_ready", int'(instr_ready), 1);
    end
    instr_valid = 1'b0;
    m_pc = 8'd12;

    for (int i = 0; i < 11; i++)
      do_instr(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].tgt, vecs[i].tk);

    // instr_valid held through EVAL and FLUSH: only one accept.
    instr_valid = 1'b1;
    opcode = 8'h20; arg1 = 8'h09; arg2 = 8'h09; target = 8'h60;
    @(negedge clk);
    chk("hold_eval_ready", int'(instr_ready), 0);
    @(negedge clk);
    m_pc  = 8'h60;
    m_cnt = m_cnt + 8'd1;
    chk("hold_flush", int'(flush), 1);
    chk("hold_pc", int'(pc), int'(m_pc));
    @(negedge clk);
    chk("hold_ready", int'(instr_ready), 1);
    chk("hold_no_reaccept_pc", int'(pc), int'(m_pc));
    chk("hold_count", int'(taken_count), int'(m_cnt));
    instr_valid = 1'b0;

    // Asynchronous reset landing in FLUSH.
    instr_valid = 1'b1;
    opcode = 8'h25; arg1 = 8'h11; arg2 = 8'h11; target = 8'hA4;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_flush", int'(flush), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", int'(pc), 0);
    chk("mid_rst_flush", int'(flush), 0);
    chk("mid_rst_taken", int'(taken), 0);
    chk("mid_rst_illegal", int'(illegal), 0);
    chk("mid_rst_count", int'(taken_count), 0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 8'h00; m_cnt = 8'h00; m_ill = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", int'(instr_ready), 1);

    // Counter saturation.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      do_instr(8'h25, v, v, 8'($urandom), 1'b1);
    end
    chk("sat_count", int'(taken_count), 255);

    // Randomized instructions against the model.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] op, a1, a2, tgt;
      op      = 8'($urandom);
      op[3:0] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      a1      = 8'($urandom);
      a2      = ($urandom_range(0, 3) == 0) ? a1 : 8'($urandom);
      tgt     = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("rand_idle_pc", int'(pc), int'(m_pc));
      end
      do_instr(op, a1, a2, tgt, op[5] ? ref_taken(op, a1, a2) : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
